attn_ram_rd_sched: RTL and testbench

//  Read-side sequencer for the ping-pong (Q*K^T) attention score RAM pair. Waits for a filled bank, walks

---
 rtl/attn_ram_rd_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_attn_ram_rd_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/attn_ram_rd_sched.sv
// rtl/attn_ram_rd_sched.sv - read sequencer for the ping-pong attention score RAM (optional ATTN_RD_TRANSPOSE_EN)
//
// Waits for a filled bank, issues read addresses for every word of the bank,
// absorbs the 1-cycle BRAM latency in a 2-entry skid buffer and streams the
// scores out on a valid/ready handshake. Done pulses once the final beat has
// been accepted, which hands the bank back to the writer.
//
// Build option ATTN_RD_TRANSPOSE_EN: addresses are walked column-major
// (addr = r*ROW_LEN + c with r fastest). Without it, addresses are row-major
// and sequential. The beat tags are always by beat count.

module attn_ram_rd_sched #(
  parameter int DATA_W  = 20,
  parameter int ADDR_W  = 12,
  parameter int ROW_LEN = 64,
  parameter int DEPTH   = 4096
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              i_enable,
  input  logic              i_AttnRAM_Empty,
  output logic [ADDR_W-1:0] o_AttnRam_rd_addr,
  input  logic [DATA_W-1:0] i_AttnRAM_data,
  output logic              o_AttnRam_Done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last_row,
  output logic              o_last_frame,
  output logic              o_busy
);

  localparam int ROW_W = $clog2(ROW_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT              state;
  logic               doneQ;
  logic               busyQ;

  // address generation
  logic [ADDR_W-1:0]  addrQ;
  logic [ADDR_W-1:0]  issueIdx;
  logic [ROW_W-1:0]   innerCnt;
  logic [ROW_W-1:0]   outerCnt;
  logic [ROW_W-1:0]   nextInner;
  logic [ROW_W-1:0]   nextOuter;
  logic [ADDR_W-1:0]  addrNext;

  // read in flight and its beat tags
  logic               inflight;
  logic               inflightLastRow;
  logic               inflightLastFrame;

  // skid buffer, entry 0 is the head
  logic [1:0]         skidVld;
  logic [DATA_W-1:0]  skidData0;
  logic [DATA_W-1:0]  skidData1;
  logic               skidLastRow0;
  logic               skidLastRow1;
  logic               skidLastFrame0;
  logic               skidLastFrame1;

  logic               pop;
  logic               push;
  logic [2:0]         occupancy;
  logic               issue;
  logic               issueLast;
  logic               issueRowEnd;

  assign pop  = skidVld[0] & i_ready;
  assign push = inflight;

  // Words already held or still on their way after this cycle's pop; a new
  // read is only launched if its word is guaranteed a free skid slot.
  assign occupancy   = 3'(skidVld[0]) + 3'(skidVld[1]) + 3'(inflight) - 3'(pop);
  assign issue       = (state == READ) && (occupancy < 3'd2);
  assign issueLast   = issue && (issueIdx == ADDR_W'(DEPTH - 1));
  assign issueRowEnd = (innerCnt == ROW_W'(ROW_LEN - 1));

  // Next position in the bank walk; the final issue parks everything at 0
  // so the next frame starts from the first word.
  always_comb begin
    nextInner = innerCnt + 1'b1;
    nextOuter = outerCnt;
    if (issueRowEnd) begin
      nextInner = '0;
      nextOuter = outerCnt + 1'b1;
    end
    if (issueLast) begin
      nextInner = '0;
      nextOuter = '0;
    end
`ifdef ATTN_RD_TRANSPOSE_EN
    addrNext = ADDR_W'(nextInner) * ADDR_W'(ROW_LEN) + ADDR_W'(nextOuter);
`else
    addrNext = ADDR_W'(nextOuter) * ADDR_W'(ROW_LEN) + ADDR_W'(nextInner);
`endif
  end

  // Advance the read address and walk counters only when a read is issued.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      addrQ    <= '0;
      issueIdx <= '0;
      innerCnt <= '0;
      outerCnt <= '0;
    end else if (issue) begin
      addrQ    <= addrNext;
      issueIdx <= issueLast ? '0 : issueIdx + 1'b1;
      innerCnt <= nextInner;
      outerCnt <= nextOuter;
    end
  end

  // Track the single outstanding BRAM read together with its beat tags.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      inflight          <= 1'b0;
      inflightLastRow   <= 1'b0;
      inflightLastFrame <= 1'b0;
    end else begin
      inflight          <= issue;
      inflightLastRow   <= issue & issueRowEnd;
      inflightLastFrame <= issueLast;
    end
  end

  // Two-entry skid FIFO: returned words enter behind the head, pops shift down.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      skidVld        <= 2'b00;
      skidData0      <= '0;
      skidData1      <= '0;
      skidLastRow0   <= 1'b0;
      skidLastRow1   <= 1'b0;
      skidLastFrame0 <= 1'b0;
      skidLastFrame1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!skidVld[0]) begin
            skidData0      <= i_AttnRAM_data;
            skidLastRow0   <= inflightLastRow;
            skidLastFrame0 <= inflightLastFrame;
            skidVld[0]     <= 1'b1;
          end else begin
            skidData1      <= i_AttnRAM_data;
            skidLastRow1   <= inflightLastRow;
            skidLastFrame1 <= inflightLastFrame;
            skidVld[1]     <= 1'b1;
          end
        end
        2'b01: begin
          skidData0      <= skidData1;
          skidLastRow0   <= skidLastRow1;
          skidLastFrame0 <= skidLastFrame1;
          skidVld        <= {1'b0, skidVld[1]};
        end
        2'b11: begin
          if (skidVld[1]) begin
            skidData0      <= skidData1;
            skidLastRow0   <= skidLastRow1;
            skidLastFrame0 <= skidLastFrame1;
            skidData1      <= i_AttnRAM_data;
            skidLastRow1   <= inflightLastRow;
            skidLastFrame1 <= inflightLastFrame;
          end else begin
            skidData0      <= i_AttnRAM_data;
            skidLastRow0   <= inflightLastRow;
            skidLastFrame0 <= inflightLastFrame;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Frame sequencing with registered busy and done flags.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= IDLE;
      doneQ <= 1'b0;
      busyQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable && !i_AttnRAM_Empty) begin
            state <= READ;
            busyQ <= 1'b1;
          end
        end
        READ: begin
          if (issueLast) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((skidVld == 2'b00) && !inflight && !pop) begin
            state <= DONE;
            doneQ <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          doneQ <= 1'b0;
          busyQ <= 1'b0;
        end
        default: begin
          state <= IDLE;
          doneQ <= 1'b0;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  assign o_AttnRam_rd_addr = addrQ;
  assign o_AttnRam_Done    = doneQ;
  assign o_busy            = busyQ;
  assign o_data            = skidData0;
  assign o_valid           = skidVld[0];
  assign o_last_row        = skidVld[0] & skidLastRow0;
  assign o_last_frame      = skidVld[0] & skidLastFrame0;

endmodule

// File: tb/tb_attn_ram_rd_sched.sv
// tb/tb_attn_ram_rd_sched.sv - directed bench for attn_ram_rd_sched

module tb_attn_ram_rd_sched;

  logic        s_clk = 1'b0;
  logic        s_rst_n;
  logic        i_enable;
  logic        i_AttnRAM_Empty;
  logic [11:0] o_AttnRam_rd_addr;
  logic [19:0] i_AttnRAM_data;
  logic        o_AttnRam_Done;
  logic [19:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last_row;
  logic        o_last_frame;
  logic        o_busy;

  logic        bank = 1'b0;
  int          checks = 0;
  int          errors = 0;

  attn_ram_rd_sched dut (
    .s_clk             (s_clk),
    .s_rst_n           (s_rst_n),
    .i_enable          (i_enable),
    .i_AttnRAM_Empty   (i_AttnRAM_Empty),
    .o_AttnRam_rd_addr (o_AttnRam_rd_addr),
    .i_AttnRAM_data    (i_AttnRAM_data),
    .o_AttnRam_Done    (o_AttnRam_Done),
    .o_data            (o_data),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_last_row        (o_last_row),
    .o_last_frame      (o_last_frame),
    .o_busy            (o_busy)
  );

  always #5 s_clk = ~s_clk;

  // Distinct content per bank and per address.
  function automatic logic [19:0] wordOf(input logic b, input int a);
    return 20'(a * 3 + 1) ^ (b ? 20'hF0000 : 20'h00000);
  endfunction

  // Address expected for the k-th issued read.
  function automatic int expAddr(input int k);
`ifdef ATTN_RD_TRANSPOSE_EN
    return (k % 64) * 64 + k / 64;
`else
    return k;
`endif
  endfunction

  // BRAM model with 1-cycle read latency; bank pointer flips on Done.
  always @(posedge s_clk) begin
    i_AttnRAM_data <= wordOf(bank, int'(o_AttnRam_rd_addr));
    if (o_AttnRam_Done) bank <= ~bank;
  end

  // Runs one frame from IDLE and gathers statistics; called at a negedge.
  task automatic runFrame(input bit randReady, input int stopAt, input int dropEnAt,
                          input bit keepAvail,
                          output int beats, output int dataErrs, output int tagErrs,
                          output int stallErrs, output int addrErrs, output int doneCnt,
                          output int doneCyc, output int firstValid, output int busyCycles,
                          output bit startBusy, output bit timedOut);
    logic        fb;
    logic        prevValid;
    logic        prevReady;
    logic [19:0] prevData;
    logic [11:0] prevAddr;
    int          addrIdx;
    int          cyc;
    int          ea;
    fb = bank;
    beats = 0; dataErrs = 0; tagErrs = 0; stallErrs = 0; addrErrs = 0;
    doneCnt = 0; doneCyc = -1; firstValid = -1; busyCycles = -1;
    prevValid = 1'b0; prevReady = 1'b1; prevData = '0;
    i_AttnRAM_Empty = 1'b0;
    @(negedge s_clk);
    startBusy = o_busy;
    if (!keepAvail) i_AttnRAM_Empty = 1'b1;
    if (o_AttnRam_rd_addr !== 12'(expAddr(0))) addrErrs++;
    prevAddr = o_AttnRam_rd_addr;
    addrIdx = 1;
    cyc = 0;
    timedOut = 1'b1;
    while (cyc < 20000) begin
      if (stopAt >= 0 && beats == stopAt) begin timedOut = 1'b0; break; end
      if (!o_busy) begin busyCycles = cyc; timedOut = 1'b0; break; end
      if (cyc == dropEnAt) i_enable = 1'b0;
      if (o_AttnRam_Done) begin doneCnt++; doneCyc = cyc; end
      if (o_valid && firstValid < 0) firstValid = cyc;
      if (prevValid && !prevReady && (!o_valid || o_data !== prevData)) stallErrs++;
      if (o_AttnRam_rd_addr !== prevAddr) begin
        ea = (addrIdx == 4096) ? 0 : expAddr(addrIdx);
        if (o_AttnRam_rd_addr !== 12'(ea)) addrErrs++;
        addrIdx++;
        prevAddr = o_AttnRam_rd_addr;
      end
      i_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && i_ready) begin
        if (o_data !== wordOf(fb, expAddr(beats))) dataErrs++;
        if (o_last_row !== ((beats % 64) == 63) || o_last_frame !== (beats == 4095)) tagErrs++;
        beats++;
      end
      prevValid = o_valid; prevReady = i_ready; prevData = o_data;
      @(negedge s_clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int busyHigh;
    s_rst_n = 1'b0; i_enable = 1'b1; i_AttnRAM_Empty = 1'b1; i_ready = 1'b1;
    repeat (3) @(negedge s_clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_AttnRam_Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_AttnRam_Done); end
    checks++; if (o_AttnRam_rd_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", o_AttnRam_rd_addr); end
    checks++; if (o_data !== 20'd0 || o_last_row !== 1'b0 || o_last_frame !== 1'b0) begin
      errors++; $display("FAIL reset_data got %h/%b/%b want 0/0/0", o_data, o_last_row, o_last_frame);
    end
    s_rst_n = 1'b1;
    busyHigh = 0;
    repeat (20) begin
      @(negedge s_clk);
      if (o_busy || o_valid || o_AttnRam_rd_addr != 12'd0) busyHigh++;
    end
    checks++; if (busyHigh !== 0) begin errors++; $display("FAIL empty_stays_idle active cycles %0d want 0", busyHigh); end
  endtask

  task automatic test_full_frame();
    int beats, de, te, se, ae, dc, dcyc, fv, bc;
    bit sb, to;
    logic fb;
    fb = bank;
    runFrame(1'b0, -1, -1, 1'b0, beats, de, te, se, ae, dc, dcyc, fv, bc, sb, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_timeout got %b want 0", to); end
    checks++; if (sb !== 1'b1) begin errors++; $display("FAIL full_start_busy got %b want 1", sb); end
    checks++; if (beats !== 4096) begin errors++; $display("FAIL full_beats got %0d want 4096", beats); end
    checks++; if (de !== 0) begin errors++; $display("FAIL full_data bad beats %0d want 0", de); end
    checks++; if (te !== 0) begin errors++; $display("FAIL full_tags bad beats %0d want 0", te); end
    checks++; if (ae !== 0) begin errors++; $display("FAIL full_addr_seq bad addrs %0d want 0", ae); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", dc); end
    checks++; if (dcyc !== 4099) begin errors++; $display("FAIL full_done_cycle got %0d want 4099", dcyc); end
    checks++; if (fv !== 2) begin errors++; $display("FAIL full_first_valid got %0d want 2", fv); end
    checks++; if (bc !== 4100) begin errors++; $display("FAIL full_busy_cycles got %0d want 4100", bc); end
    checks++; if (o_AttnRam_rd_addr !== 12'd0) begin errors++; $display("FAIL full_end_addr got %0d want 0", o_AttnRam_rd_addr); end
    checks++; if (bank !== ~fb) begin errors++; $display("FAIL full_bank_flip got %b want %b", bank, ~fb); end
  endtask

  task automatic test_backpressure();
    int beats, de, te, se, ae, dc, dcyc, fv, bc, act;
    bit sb, to;
    runFrame(1'b1, -1, 100, 1'b0, beats, de, te, se, ae, dc, dcyc, fv, bc, sb, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b want 0", to); end
    checks++; if (beats !== 4096) begin errors++; $display("FAIL bp_beats got %0d want 4096", beats); end
    checks++; if (de !== 0) begin errors++; $display("FAIL bp_data bad beats %0d want 0", de); end
    checks++; if (te !== 0) begin errors++; $display("FAIL bp_tags bad beats %0d want 0", te); end
    checks++; if (se !== 0) begin errors++; $display("FAIL bp_stall_stable violations %0d want 0", se); end
    checks++; if (ae !== 0) begin errors++; $display("FAIL bp_addr_seq bad addrs %0d want 0", ae); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", dc); end
    // enable was dropped mid-frame: a filled bank must not start a new frame
    i_ready = 1'b1;
    i_AttnRAM_Empty = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge s_clk);
      if (o_busy) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL disabled_stays_idle busy cycles %0d want 0", act); end
    i_AttnRAM_Empty = 1'b1;
    i_enable = 1'b1;
    @(negedge s_clk);
  endtask

  task automatic test_back_to_back();
    int beats, de, te, se, ae, dc, dcyc, fv, bc;
    bit sb, to;
    logic fb;
    fb = bank;
    runFrame(1'b0, -1, -1, 1'b1, beats, de, te, se, ae, dc, dcyc, fv, bc, sb, to);
    checks++; if (beats !== 4096 || de !== 0 || dc !== 1 || to !== 1'b0) begin
      errors++; $display("FAIL b2b_frame1 beats %0d dataerr %0d done %0d want 4096/0/1", beats, de, dc);
    end
    runFrame(1'b0, -1, -1, 1'b0, beats, de, te, se, ae, dc, dcyc, fv, bc, sb, to);
    checks++; if (sb !== 1'b1) begin errors++; $display("FAIL b2b_one_idle_cycle got busy %b want 1", sb); end
    checks++; if (beats !== 4096 || de !== 0 || dc !== 1 || to !== 1'b0) begin
      errors++; $display("FAIL b2b_frame2 beats %0d dataerr %0d done %0d want 4096/0/1", beats, de, dc);
    end
    checks++; if (bank !== fb) begin errors++; $display("FAIL b2b_bank got %b want %b", bank, fb); end
  endtask

  task automatic test_reset_mid_frame();
    int beats, de, te, se, ae, dc, dcyc, fv, bc;
    bit sb, to;
    logic fb;
    fb = bank;
    runFrame(1'b0, 1000, -1, 1'b0, beats, de, te, se, ae, dc, dcyc, fv, bc, sb, to);
    checks++; if (beats !== 1000 || de !== 0 || dc !== 0) begin
      errors++; $display("FAIL mid_partial beats %0d dataerr %0d done %0d want 1000/0/0", beats, de, dc);
    end
    s_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_AttnRam_rd_addr !== 12'd0 || o_AttnRam_Done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clear got busy %b valid %b addr %0d done %b want 0/0/0/0",
                         o_busy, o_valid, o_AttnRam_rd_addr, o_AttnRam_Done);
    end
    @(negedge s_clk);
    s_rst_n = 1'b1;
    @(negedge s_clk);
    checks++; if (bank !== fb) begin errors++; $display("FAIL mid_no_done bank got %b want %b", bank, fb); end
    runFrame(1'b0, -1, -1, 1'b0, beats, de, te, se, ae, dc, dcyc, fv, bc, sb, to);
    checks++; if (beats !== 4096 || de !== 0 || ae !== 0) begin
      errors++; $display("FAIL mid_reread beats %0d dataerr %0d addrerr %0d want 4096/0/0", beats, de, ae);
    end
    checks++; if (dc !== 1 || to !== 1'b0) begin errors++; $display("FAIL mid_reread_done got %0d want 1", dc); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
